tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 The block SHALL have parameter TOL, default 8, giving the ± match tolerance in clock cycles per half-period.
REQ-002 The block SHALL have parameter TIMEOUT, default 4999, giving the edge-free cycle count that declares silence.
REQ-003 clk_1MHz  input  1  sole clock, 1 MHz; all state on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tone_in  input  1  square wave from a buzzer source, asynchronous to clk_1MHz.
REQ-006 sel_out  output  7  one-hot decoded key, bit6 = first note … bit0 = seventh note; 0 when not locked.
REQ-007 flat_out  output  1  1 = decoded note is the flat variant; 0 when not locked.
REQ-008 octave_out  output  1  1 = upper octave; 0 when not locked.
REQ-009 valid  output  1  high while LOCKED.
REQ-010 note_change  output  1  one-cycle pulse on each entry into LOCKED.

Function
REQ-011 tone_in SHALL pass through a 2-flop synchronizer; an edge pulse SHALL fire for either polarity of change at the synchronizer output.
REQ-012 A 13-bit interval counter SHALL clear to 0 on an edge pulse, otherwise increment, saturating at TIMEOUT.
REQ-013 On an edge pulse the measured half-period SHALL be M = counter+1, i.e. the exact cycle spacing between consecutive edge pulses.
REQ-014 M SHALL match a table entry H when |M−H| ≤ TOL; unsigned compare, no wrap.
REQ-015 Table, octave0 flat0, sel bit6..bit0: 3823, 3405, 3034, 2863, 2551, 2273, 2025.
REQ-016 Table, octave0 flat1: bit5 3608, bit4 3214, bit2 2703, bit1 2408, bit0 2146; bits 6 and 3 have no flat entry.
REQ-017 Table, octave1 flat0, bit6..bit0: 1911, 1702, 1516, 1431, 1275, 1136, 1012.
REQ-018 Table, octave1 flat1: bit5 1804, bit4 1607, bit2 1352, bit1 1204, bit0 1073.
REQ-019 Entries are ≥ 60 cycles apart; with TOL ≤ 8 at most one entry SHALL match.
REQ-020 States: SILENT, ARMED, CANDIDATE, LOCKED.
REQ-021 SILENT: edge pulse -> ARMED. No interval is measured from the first edge.
REQ-022 ARMED: edge with match -> CANDIDATE, storing code {octave, flat, sel}. Edge without match -> stay ARMED.
REQ-023 CANDIDATE, edge with match to the same code -> LOCKED.
REQ-024 CANDIDATE, edge with match to a different code -> stay CANDIDATE, storing the new code.
REQ-025 CANDIDATE, edge without match -> ARMED.
REQ-026 LOCKED, edge with match to the same code -> stay LOCKED.
REQ-027 LOCKED, edge with match to a different code -> CANDIDATE with the new code; valid drops.
REQ-028 LOCKED, edge without match -> ARMED.
REQ-029 From any non-SILENT state, counter reaching TIMEOUT with no edge -> SILENT.
REQ-030 Edge pulse and timeout in the same cycle: the edge SHALL take priority.
REQ-031 Outputs SHALL be registered. valid, sel_out, flat_out and octave_out SHALL update one cycle after the edge pulse that causes the transition.
REQ-032 note_change SHALL pulse in that same cycle.
REQ-033 Any transition out of LOCKED SHALL zero sel_out, flat_out, octave_out and valid in the following cycle.
REQ-034 Edge-to-output latency from a tone_in transition SHALL be 4 cycles: 2 synchronizer + 1 edge/decode + 1 output register.

Reset
REQ-035 rst high SHALL, at the next clock edge, clear the synchronizer, counter, stored code and all outputs, and force SILENT.
REQ-036 Reset asserted mid-measurement or in LOCKED SHALL discard the partial interval.
REQ-037 After rst deasserts, the first edge pulse SHALL only arm; no interval is measured from it.
REQ-038 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-039 Square wave, half-period 3823 -> valid=1, sel_out=1000000, flat_out=0, octave_out=0 one cycle after the 3rd edge pulse; note_change pulses once.
REQ-040 Half-period 1204 -> sel_out=0000010, flat_out=1, octave_out=1; half-period 1212 still locks; 1213 never locks.
REQ-041 Locked on 2551, tone_in then held constant -> SILENT and all outputs 0 exactly 4999 cycles after the last edge pulse.
REQ-042 Locked on 2273, switch to 1136 -> valid drops after the first 1136 interval and relocks to octave1 bit1 one interval later.
REQ-043 Alternating intervals 3034 / 2863 -> valid never asserts; state toggles within CANDIDATE.
REQ-044 rst pulsed for 1 cycle while LOCKED on 2025 -> outputs 0 next cycle; relock requires 3 fresh edge pulses.

Source files
------------

// File: rtl/tone_decoder_if.sv
// Tone decoder signal bundle: buzzer input plus decoded note outputs.
// The master side is the decoder; the slave side is the tone source / note consumer.
interface tone_decoder_if;
   logic       tone_in;
   logic [6:0] sel_out;
   logic       flat_out;
   logic       octave_out;
   logic       valid;
   logic       note_change;

   modport master (
      input  tone_in,
      output sel_out, flat_out, octave_out, valid, note_change
   );

   modport slave (
      output tone_in,
      input  sel_out, flat_out, octave_out, valid, note_change
   );
endinterface

// File: rtl/tone_decoder.sv
// Buzzer tone decoder: measures the half-period of a square wave and locks onto
// one of 24 note codes after two consecutive matching intervals.
module tone_decoder #(
   parameter int unsigned TOL     = 8,
   parameter int unsigned TIMEOUT = 4999
) (
   input  logic           clk_1MHz,
   input  logic           rst,
   tone_decoder_if.master bus
);

   typedef enum logic [1:0] {SILENT, ARMED, CANDIDATE, LOCKED} state_t;

   localparam int unsigned NUM_ENTRIES = 24;
   localparam logic [12:0] TIMEOUT_C   = 13'(TIMEOUT);

   // Code layout is {octave, flat, sel[6:0]}
   localparam logic [12:0] HALF_TAB [NUM_ENTRIES] = '{
      13'd3823, 13'd3405, 13'd3034, 13'd2863, 13'd2551, 13'd2273, 13'd2025,
      13'd3608, 13'd3214, 13'd2703, 13'd2408, 13'd2146,
      13'd1911, 13'd1702, 13'd1516, 13'd1431, 13'd1275, 13'd1136, 13'd1012,
      13'd1804, 13'd1607, 13'd1352, 13'd1204, 13'd1073
   };

   localparam logic [8:0] CODE_TAB [NUM_ENTRIES] = '{
      9'b0_0_1000000, 9'b0_0_0100000, 9'b0_0_0010000, 9'b0_0_0001000,
      9'b0_0_0000100, 9'b0_0_0000010, 9'b0_0_0000001,
      9'b0_1_0100000, 9'b0_1_0010000, 9'b0_1_0000100, 9'b0_1_0000010,
      9'b0_1_0000001,
      9'b1_0_1000000, 9'b1_0_0100000, 9'b1_0_0010000, 9'b1_0_0001000,
      9'b1_0_0000100, 9'b1_0_0000010, 9'b1_0_0000001,
      9'b1_1_0100000, 9'b1_1_0010000, 9'b1_1_0000100, 9'b1_1_0000010,
      9'b1_1_0000001
   };

   logic        sync_1;
   logic        sync_2;
   logic        sync_3;
   logic        edge_p;
   logic [12:0] count;
   logic [13:0] meas;
   logic        hit;
   logic [8:0]  hit_code;
   state_t      state;
   logic [8:0]  cand_code;
   logic [8:0]  out_code;
   logic        valid_q;
   logic        note_change_q;

   // Registered edge pulse forms the decode stage, giving 2+1+1 cycle latency
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
         edge_p <= 1'b0;
      end else begin
         sync_1 <= bus.tone_in;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
         edge_p <= sync_2 ^ sync_3;
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst || edge_p) begin
         count <= '0;
      end else if (count < TIMEOUT_C) begin
         count <= count + 13'd1;
      end
   end

   assign meas = {1'b0, count} + 14'd1;

   // |meas - H| <= TOL, rearranged so neither side can underflow
   always_comb begin
      hit      = 1'b0;
      hit_code = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if ((meas + 14'(TOL) >= {1'b0, HALF_TAB[i]}) &&
             (meas <= {1'b0, HALF_TAB[i]} + 14'(TOL))) begin
            hit      = 1'b1;
            hit_code = CODE_TAB[i];
         end
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         state         <= SILENT;
         cand_code     <= '0;
         out_code      <= '0;
         valid_q       <= 1'b0;
         note_change_q <= 1'b0;
      end else begin
         note_change_q <= 1'b0;
         if (edge_p) begin
            unique case (state)
               SILENT: state <= ARMED;
               ARMED: begin
                  if (hit) begin
                     state     <= CANDIDATE;
                     cand_code <= hit_code;
                  end
               end
               CANDIDATE: begin
                  if (!hit) begin
                     state <= ARMED;
                  end else if (hit_code == cand_code) begin
                     state         <= LOCKED;
                     out_code      <= hit_code;
                     valid_q       <= 1'b1;
                     note_change_q <= 1'b1;
                  end else begin
                     cand_code <= hit_code;
                  end
               end
               LOCKED: begin
                  if (!hit) begin
                     state    <= ARMED;
                     out_code <= '0;
                     valid_q  <= 1'b0;
                  end else if (hit_code != cand_code) begin
                     state     <= CANDIDATE;
                     cand_code <= hit_code;
                     out_code  <= '0;
                     valid_q   <= 1'b0;
                  end
               end
               default: state <= SILENT;
            endcase
         end else if ((state != SILENT) && (count >= TIMEOUT_C - 13'd1)) begin
            // Leave as the counter steps onto TIMEOUT
            state    <= SILENT;
            out_code <= '0;
            valid_q  <= 1'b0;
         end
      end
   end

   assign bus.octave_out  = out_code[8];
   assign bus.flat_out    = out_code[7];
   assign bus.sel_out     = out_code[6:0];
   assign bus.valid       = valid_q;
   assign bus.note_change = note_change_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: lock, tolerance edges, timeout, note switch,
// alternating notes and reset while locked.
`timescale 1ns/1ps
module tb_tone_decoder;

   logic clk_1MHz = 1'b0;
   logic rst;

   tone_decoder_if bus ();

   tone_decoder #(.TOL(8), .TIMEOUT(4999)) dut (
      .clk_1MHz (clk_1MHz),
      .rst      (rst),
      .bus      (bus)
   );

   always #500 clk_1MHz = ~clk_1MHz;

   int errors     = 0;
   int checks     = 0;
   int nc_count   = 0;
   int valid_seen = 0;

   always @(negedge clk_1MHz) begin
      if (bus.note_change === 1'b1) nc_count++;
      if (bus.valid === 1'b1) valid_seen++;
   end

   initial begin
      #200_000_000;
      $display("FAIL watchdog: time limit reached, got no summary, want finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_1MHz);
   endtask

   task automatic tone_edge();
      bus.tone_in = ~bus.tone_in;
   endtask

   task automatic do_reset();
      bus.tone_in = 1'b0;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
   endtask

   // obs layout: {valid, octave, flat, sel[6:0]}
   task automatic test_reset();
      logic [10:0] obs;
      bus.tone_in = 1'b0;
      rst = 1'b1;
      cyc(3);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, bus.note_change};
      checks++;
      if (obs !== 11'b0) begin
         errors++;
         $display("FAIL reset_during: got %b want %b", obs, 11'b0);
      end
      rst = 1'b0;
      cyc(2);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, bus.note_change};
      checks++;
      if (obs !== 11'b0) begin
         errors++;
         $display("FAIL reset_after: got %b want %b", obs, 11'b0);
      end
   endtask

   task automatic test_lock_3823();
      logic [9:0] obs;
      int base;
      do_reset();
      base = nc_count;
      tone_edge(); cyc(3823);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL lock3823_after2: got %b want %b", obs, 10'b0);
      end
      cyc(3819);
      tone_edge(); cyc(3);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL lock3823_latency3: got %b want %b", obs, 10'b0);
      end
      cyc(1);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_1000000) begin
         errors++;
         $display("FAIL lock3823_latency4: got %b want %b", obs, 10'b1_0_0_1000000);
      end
      checks++;
      if (bus.note_change !== 1'b1) begin
         errors++;
         $display("FAIL lock3823_nc_high: got %b want 1", bus.note_change);
      end
      cyc(1);
      checks++;
      if (bus.note_change !== 1'b0) begin
         errors++;
         $display("FAIL lock3823_nc_low: got %b want 0", bus.note_change);
      end
      cyc(3818);
      tone_edge(); cyc(5);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_1000000) begin
         errors++;
         $display("FAIL lock3823_hold: got %b want %b", obs, 10'b1_0_0_1000000);
      end
      checks++;
      if (nc_count - base !== 1) begin
         errors++;
         $display("FAIL lock3823_nc_count: got %0d want 1", nc_count - base);
      end
   endtask

   task automatic test_tolerance();
      int          halves [5] = '{1204, 1212, 1196, 1213, 1195};
      logic [9:0]  expv   [5] = '{10'b1_1_1_0000010, 10'b1_1_1_0000010,
                                  10'b1_1_1_0000010, 10'b0, 10'b0};
      logic [9:0]  obs;
      for (int i = 0; i < 5; i++) begin
         do_reset();
         tone_edge(); cyc(halves[i]);
         tone_edge(); cyc(halves[i]);
         tone_edge(); cyc(4);
         obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
         checks++;
         if (obs !== expv[i]) begin
            errors++;
            $display("FAIL tolerance_%0d: got %b want %b", halves[i], obs, expv[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [9:0] obs;
      do_reset();
      tone_edge(); cyc(2551);
      tone_edge(); cyc(2551);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_0000100) begin
         errors++;
         $display("FAIL timeout_lock: got %b want %b", obs, 10'b1_0_0_0000100);
      end
      cyc(4998);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_0000100) begin
         errors++;
         $display("FAIL timeout_early: got %b want %b", obs, 10'b1_0_0_0000100);
      end
      cyc(1);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL timeout_silent: got %b want %b", obs, 10'b0);
      end
   endtask

   task automatic test_switch();
      logic [9:0] obs;
      do_reset();
      tone_edge(); cyc(2273);
      tone_edge(); cyc(2273);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_0000010) begin
         errors++;
         $display("FAIL switch_lock2273: got %b want %b", obs, 10'b1_0_0_0000010);
      end
      cyc(1132);
      tone_edge(); cyc(3);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_0000010) begin
         errors++;
         $display("FAIL switch_before_drop: got %b want %b", obs, 10'b1_0_0_0000010);
      end
      cyc(1);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b0) begin
         errors++;
         $display("FAIL switch_drop: got %b want %b", obs, 10'b0);
      end
      cyc(1132);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_1_0_0000010) begin
         errors++;
         $display("FAIL switch_relock1136: got %b want %b", obs, 10'b1_1_0_0000010);
      end
      checks++;
      if (bus.note_change !== 1'b1) begin
         errors++;
         $display("FAIL switch_nc: got %b want 1", bus.note_change);
      end
   endtask

   task automatic test_alternate();
      logic [9:0] obs;
      int base;
      do_reset();
      base = valid_seen;
      tone_edge();
      for (int i = 0; i < 4; i++) begin
         cyc((i % 2 == 0) ? 3034 : 2863);
         tone_edge();
      end
      cyc(4);
      checks++;
      if (valid_seen - base !== 0) begin
         errors++;
         $display("FAIL alternate_never_valid: got %0d valid cycles want 0", valid_seen - base);
      end
      cyc(2859);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out};
      checks++;
      if (obs !== 10'b1_0_0_0001000) begin
         errors++;
         $display("FAIL alternate_then_lock: got %b want %b", obs, 10'b1_0_0_0001000);
      end
   endtask

   task automatic test_reset_locked();
      logic [10:0] obs;
      do_reset();
      tone_edge(); cyc(2025);
      tone_edge(); cyc(2025);
      tone_edge(); cyc(2025);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, 1'b0};
      checks++;
      if (obs !== 11'b1_0_0_0000001_0) begin
         errors++;
         $display("FAIL rstlock_lock2025: got %b want %b", obs, 11'b1_0_0_0000001_0);
      end
      cyc(996);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, bus.note_change};
      checks++;
      if (obs !== 11'b0) begin
         errors++;
         $display("FAIL rstlock_cleared: got %b want %b", obs, 11'b0);
      end
      cyc(1024);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, 1'b0};
      checks++;
      if (obs !== 11'b0) begin
         errors++;
         $display("FAIL rstlock_edge1: got %b want %b", obs, 11'b0);
      end
      cyc(2021);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, 1'b0};
      checks++;
      if (obs !== 11'b0) begin
         errors++;
         $display("FAIL rstlock_edge2: got %b want %b", obs, 11'b0);
      end
      cyc(2021);
      tone_edge(); cyc(4);
      obs = {bus.valid, bus.octave_out, bus.flat_out, bus.sel_out, bus.note_change};
      checks++;
      if (obs !== 11'b1_0_0_0000001_1) begin
         errors++;
         $display("FAIL rstlock_edge3: got %b want %b", obs, 11'b1_0_0_0000001_1);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.tone_in = 1'b0;
      test_reset();
      test_lock_3823();
      test_tolerance();
      test_timeout();
      test_switch();
      test_alternate();
      test_reset_locked();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
